// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester arbiter for one synchronous data-memory port
//
// Purpose: shares a single-cycle-latency, byte-masked memory port between
// requesters A and B. Round-robin with a bounded burst length: the current
// owner keeps the port for up to MAX_BURST consecutive grants while the other
// side is waiting, then has to hand it over.
//
// Ports:
//   clk, reset                    clock; asynchronous active-low reset
//   a_req/a_wmask/a_addr/a_wdata  requester A access (wmask 0 = read)
//   a_gnt, a_rvalid, a_rdata      A grant (combinational), read return (+1 cycle)
//   b_*                           same for requester B
//   mem_cen/mem_wmask/mem_addr/mem_wdata  memory port drive
//   mem_data                      memory read data, valid one cycle after access
//
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN. When defined, A always wins a
// tie and the burst counter / last-winner registers are removed.
module dmem_port_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [3:0]  a_wmask,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [3:0]  b_wmask,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        mem_cen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e state_q, state_d;
  logic   win_a, win_b;
  logic   a_rvalid_q, b_rvalid_q;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_q, last_d;      // 1: B won the most recent grant
  logic             burst_full;

  // Counter saturates at MAX_BURST, so ">=" and "==" are equivalent here.
  assign burst_full = (burst_cnt_q >= CNT_W'(MAX_BURST));
`endif

  // Winner selection
  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (a_req)      win_a = 1'b1;
    else if (b_req) win_b = 1'b1;
`else
    case (state_q)
      OWN_A: begin
        if (a_req && (!burst_full || !b_req)) win_a = 1'b1;
        else if (b_req)                       win_b = 1'b1;
      end
      OWN_B: begin
        if (b_req && (!burst_full || !a_req)) win_b = 1'b1;
        else if (a_req)                       win_a = 1'b1;
      end
      default: begin
        if (a_req && b_req) begin
          win_a = last_q;
          win_b = !last_q;
        end else begin
          win_a = a_req;
          win_b = b_req;
        end
      end
    endcase
`endif
  end

  // Nothing is issued while reset is held, even though inputs may be active.
  assign a_gnt   = win_a & reset;
  assign b_gnt   = win_b & reset;
  assign mem_cen = a_gnt | b_gnt;

  // Next state
  always_comb begin
    state_d = IDLE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    burst_cnt_d = '0;
    last_d      = last_q;
`endif
    if (a_gnt) begin
      state_d = OWN_A;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_d = 1'b0;
      if (state_q != OWN_A)  burst_cnt_d = CNT_W'(1);
      else if (burst_full)   burst_cnt_d = burst_cnt_q;
      else                   burst_cnt_d = burst_cnt_q + CNT_W'(1);
`endif
    end else if (b_gnt) begin
      state_d = OWN_B;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_d = 1'b1;
      if (state_q != OWN_B)  burst_cnt_d = CNT_W'(1);
      else if (burst_full)   burst_cnt_d = burst_cnt_q;
      else                   burst_cnt_d = burst_cnt_q + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_q <= '0;
      last_q      <= 1'b1;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
    end
  end
`endif

  // Memory drive
  always_comb begin
    mem_addr  = a_addr;
    mem_wdata = a_wdata;
    mem_wmask = 4'b0000;
    if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_wmask = b_wmask;
    end else if (a_gnt) begin
      mem_wmask = a_wmask;
    end
  end

  // Read return: the memory's output register lines up with these flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_gnt && (a_wmask == 4'b0000);
      b_rvalid_q <= b_gnt && (b_wmask == 4'b0000);
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? mem_data : 32'h0;
  assign b_rdata  = b_rvalid_q ? mem_data : 32'h0;

endmodule
